// File: rtl/mem_access_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl_pkg
//   Shared definitions for the MEM-stage data-memory access sequencer:
//   access-size codes, sequencer state encoding and the alignment check
//   used by the request-detect logic.
// -----------------------------------------------------------------------------
package mem_access_ctrl_pkg;

    // Access size codes as presented on mem_size (2'b11 behaves as word).
    localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
    localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
    localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

    // Sequencer states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_DONE = 2'b10
    } mac_state_e;

    // Half accesses need an even address, word (and code 11) accesses need a
    // word-aligned address; bytes are always aligned.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        logic mis;
        case (size)
            MEM_SIZE_BYTE: mis = 1'b0;
            MEM_SIZE_HALF: mis = addr_lo[0];
            default:       mis = |addr_lo;
        endcase
        return mis;
    endfunction

endpackage : mem_access_ctrl_pkg

// File: rtl/mem_access_ctrl_lane_align.sv
// -----------------------------------------------------------------------------
// mem_lane_align
//   Purely combinational byte-lane steering for the data bus.
//   Store side: byte enables and lane-replicated write data.
//   Load side : lane extraction from the raw bus word plus sign/zero extension.
//
// Ports
//   size_i      access size code
//   addr_lo_i   byte offset within the word (address bits [1:0])
//   unsigned_i  1 = zero-extend loads, 0 = sign-extend
//   wdata_i     right-justified store data
//   rdata_i     raw 32-bit word from the bus
//   be_o        byte enables for the access
//   wdata_o     store data replicated across all candidate lanes
//   rdata_o     selected lane, extended to 32 bits
// -----------------------------------------------------------------------------
module mem_lane_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Store path: enables and replicated data.
    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        case (size_i)
            MEM_SIZE_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            MEM_SIZE_HALF: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
            end
        endcase
    end

    // Load path: pick the addressed lane, then extend.
    always_comb begin
        lane_byte = rdata_i[7:0];
        case (addr_lo_i)
            2'd0:    lane_byte = rdata_i[7:0];
            2'd1:    lane_byte = rdata_i[15:8];
            2'd2:    lane_byte = rdata_i[23:16];
            default: lane_byte = rdata_i[31:24];
        endcase
        lane_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        rdata_o = rdata_i;
        case (size_i)
            MEM_SIZE_BYTE: rdata_o = unsigned_i ? {24'h000000, lane_byte}
                                                : {{24{lane_byte[7]}}, lane_byte};
            MEM_SIZE_HALF: rdata_o = unsigned_i ? {16'h0000, lane_half}
                                                : {{16{lane_half[15]}}, lane_half};
            default:       rdata_o = rdata_i;
        endcase
    end

endmodule : mem_lane_align

// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//   Sequencer that turns a MEM-stage load/store into a req/ack transaction on
//   the data bus, stalling the pipeline until the access completes. Flags
//   misaligned accesses (no bus activity) and bus timeouts with a one-cycle
//   mem_err pulse.
//
// Parameters
//   TIMEOUT      cycles allowed in REQ without bus_ack before abort (1..255)
//
// Ports
//   clk, rst_n   pipeline clock, asynchronous active-low reset
//   mem_rd_en    load request        mem_wr_en   store request
//   mem_size     00 byte/01 half/10,11 word
//   mem_unsigned zero-extend loads   mem_addr    byte address
//   mem_wdata    right-justified store data
//   mem_stall    pipeline freeze     mem_rdata   aligned/extended load data
//   mem_valid    access complete     mem_err     misalign/timeout pulse
//   bus_req/we/addr/wdata/be         bus request side
//   bus_ack/bus_rdata                bus response side
// -----------------------------------------------------------------------------
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_rd_en,
    input  logic        mem_wr_en,
    input  logic [1:0]  mem_size,
    input  logic        mem_unsigned,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_stall,
    output logic [31:0] mem_rdata,
    output logic        mem_valid,
    output logic        mem_err,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    mac_state_e  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        stall_c;
    logic        err_c;
    logic        valid_c;
    logic [31:0] rdata_c;
    logic        in_req;

    logic [3:0]  la_be;
    logic [31:0] la_wdata;
    logic [31:0] la_rdata;

    // Single steering instance serves both directions; it always sees the
    // latched access so bus outputs stay stable for the whole REQ phase.
    mem_lane_align u_lane_align (
        .size_i     (size_q),
        .addr_lo_i  (addr_q[1:0]),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .rdata_i    (bus_rdata),
        .be_o       (la_be),
        .wdata_o    (la_wdata),
        .rdata_o    (la_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        stall_c = 1'b0;
        err_c   = 1'b0;
        valid_c = 1'b0;
        rdata_c = '0;
        in_req  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mem_rd_en || mem_wr_en) begin
                    if (is_misaligned(mem_size, mem_addr[1:0])) begin
                        // Rejected in place: error pulse, no stall, no bus cycle.
                        err_c = 1'b1;
                    end else begin
                        stall_c = 1'b1;
                        addr_d  = mem_addr;
                        size_d  = mem_size;
                        uns_d   = mem_unsigned;
                        we_d    = mem_wr_en;
                        wdata_d = mem_wdata;
                        cnt_d   = '0;
                        err_d   = 1'b0;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                in_req  = 1'b1;
                stall_c = 1'b1;
                if (bus_ack) begin
                    // Ack beats timeout even in the last allowed cycle.
                    rdata_d = we_q ? 32'h0 : la_rdata;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_q == TO_LAST) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                valid_c = 1'b1;
                rdata_c = rdata_q;
                err_c   = err_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Combinational IDLE responses follow the inputs, so hold them off while
    // reset is asserted to keep every output at its reset value.
    assign mem_stall = stall_c & rst_n;
    assign mem_err   = err_c & rst_n;
    assign mem_valid = valid_c;
    assign mem_rdata = rdata_c;

    assign bus_req   = in_req;
    assign bus_we    = in_req & we_q;
    assign bus_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus_wdata = in_req ? la_wdata : 32'h0;
    assign bus_be    = in_req ? la_be : 4'h0;

endmodule : mem_access_ctrl
